vga_timing_core: RTL
====================

// Module: vga_timing_core
// PURPOSE
//   Parameterised VGA raster timing generator. It produces registered hpos/vpos, hsync/vsync,
//   display_on and line/frame strobes, plus a free-running frame counter.
//   It feeds the pixel-pattern stages (rings, etc.) and replaces open-coded frame counters there.
//   Default timing is 640x480@60 on a 25.175 MHz pixel clock; ce allows a faster system clock.
// PARAMETERS
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   hsync pulse width (pixels)
//   H_BACK     48   horizontal back porch (pixels)
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vsync pulse width (lines)
//   V_BACK     33   vertical back porch (lines)
//   SYNC_POL   0    sync active level (0 = active-low, the VGA 640x480 default)
//   FRAME_W    10   width of frame_count
// PORTS
//   clk          in   1        system clock; the only clock in the block
//   reset        in   1        synchronous, active-high reset
//   ce           in   1        pixel advance enable; when 0 the raster holds
//   hpos         out  10       current column, 0..H_TOTAL-1
//   vpos         out  10       current line, 0..V_TOTAL-1
//   hsync        out  1        horizontal sync at SYNC_POL level when active
//   vsync        out  1        vertical sync at SYNC_POL level when active
//   display_on   out  1        1 iff hpos<H_DISPLAY && vpos<V_DISPLAY
//   line_start   out  1        1-clk strobe: hpos has just become 0
//   frame_start  out  1        1-clk strobe: (hpos,vpos) has just become (0,0)
//   frame_count  out  FRAME_W  count of frames started since reset, modulo 2^FRAME_W
// BEHAVIOUR
//   - Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
//   - All outputs are registered. Every output is mutually consistent with the current hpos/vpos: zero skew.
//   - Reset, synchronous and dominant over ce:
//       - hpos = H_TOTAL-1, vpos = V_TOTAL-1.
//       - hsync = vsync = ~SYNC_POL (inactive); display_on = 0.
//       - line_start = frame_start = 0; frame_count = all ones.
//   - Counter advance, on each clk edge with ce=1:
//       - hpos = (hpos == H_TOTAL-1) ? 0 : hpos+1.
//       - vpos increments only when hpos wraps; vpos wraps V_TOTAL-1 -> 0.
//       - The first ce after reset therefore lands on (0,0).
//   - ce=0: all counters and levels hold. line_start and frame_start are 0 on any cycle that did not advance.
//   - hsync is active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
//   - vsync is active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491.
//   - Sync ranges are decoded on position only. vsync changes on the same cycle vpos changes, at hpos=0.
//   - line_start = 1 exactly on the clk cycle after an advance into hpos=0. Each such strobe lasts one clk.
//   - frame_start = line_start && vpos==0.
//   - frame_count increments (mod 2^FRAME_W) on the same edge that raises frame_start. It reads 0 in frame 0 after reset.
//   - Wrap: frame_count all-ones -> 0, with no flag.
//   - Reset asserted mid-frame restarts the raster. There is no partial-line or partial-frame recovery.
//   - Position math uses 10-bit unsigned counters; parameters must give H_TOTAL and V_TOTAL <= 1024.
// TESTING
//   1. Release reset with ce=1 held -> next clk: hpos=0, vpos=0, frame_start=1, line_start=1, frame_count=0, display_on=1.
//   2. ce=1 continuous -> hsync low for exactly 96 clks per line (hpos 656..751).
//      vsync low for exactly 1600 clks (vpos 490..491); display_on high for 640 clks per line on lines 0..479.
//   3. ce=1 continuous -> frame_start period 420000 clks; line_start period 800 clks; frame_count steps 0,1,2.
//   4. ce toggled 1,0,1,0 -> frame_start period 840000 clks.
//      Each strobe is 1 clk wide. Outputs hold while ce=0.
//   5. Assert reset at hpos=300, vpos=200 for 3 clks -> reset values as listed; raster restarts at (0,0) after release.
//   6. Run 1024 frames (or force frame_count=1023) -> wraps to 0. SYNC_POL=1 build -> sync pulses active-high, same widths.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel-advance enable in, position/sync/strobe/frame outputs back.
interface vga_timing_if #(
  parameter int unsigned FRAME_W = 10
);
  localparam int unsigned POS_W = 10;

  logic               ce;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  // Timing generator side
  modport master (
    input  ce,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

  // Pixel-pattern consumer side
  modport slave (
    output ce,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_core.sv
// Parameterised VGA raster generator: position counters, sync/display decode,
// line/frame strobes and a free-running frame counter, all registered with zero skew.
module vga_timing_core #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned FRAME_W   = 10
) (
  input  logic           clk,
  input  logic           reset,
  vga_timing_if.master   vga
);
  localparam int unsigned POS_W    = 10;
  localparam int unsigned CMP_W    = POS_W + 1;
  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [POS_W-1:0]   hpos_q, vpos_q;
  logic               hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q;
  logic [FRAME_W-1:0] frame_count_q;

  logic [POS_W-1:0]   hpos_nx, vpos_nx;
  logic               h_wrap, hs_act_nx, vs_act_nx, disp_nx, line_nx, frame_nx;

  // Next raster position and decode of that position, so registered outputs line up with it
  always_comb begin
    h_wrap    = (hpos_q == POS_W'(H_TOTAL - 1));
    hpos_nx   = h_wrap ? '0 : hpos_q + POS_W'(1);
    vpos_nx   = vpos_q;
    if (h_wrap) begin
      vpos_nx = (vpos_q == POS_W'(V_TOTAL - 1)) ? '0 : vpos_q + POS_W'(1);
    end
    hs_act_nx = ({1'b0, hpos_nx} >= CMP_W'(HS_START)) && ({1'b0, hpos_nx} < CMP_W'(HS_END));
    vs_act_nx = ({1'b0, vpos_nx} >= CMP_W'(VS_START)) && ({1'b0, vpos_nx} < CMP_W'(VS_END));
    disp_nx   = ({1'b0, hpos_nx} < CMP_W'(H_DISPLAY)) && ({1'b0, vpos_nx} < CMP_W'(V_DISPLAY));
    line_nx   = (hpos_nx == '0);
    frame_nx  = line_nx && (vpos_nx == '0);
  end

  // Raster state: reset parks at the last pixel so the first advance lands on (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q        <= POS_W'(H_TOTAL - 1);
      vpos_q        <= POS_W'(V_TOTAL - 1);
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '1;
    end else if (vga.ce) begin
      hpos_q        <= hpos_nx;
      vpos_q        <= vpos_nx;
      hsync_q       <= hs_act_nx ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= vs_act_nx ? SYNC_POL : ~SYNC_POL;
      display_on_q  <= disp_nx;
      line_start_q  <= line_nx;
      frame_start_q <= frame_nx;
      if (frame_nx) begin
        frame_count_q <= frame_count_q + FRAME_W'(1);
      end
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;
endmodule
